rx_fifo_drain_ctrl: RTL and testbench

Clocked controller that sequences the UART receive FIFO. It turns receiver byte strobes into FIFO write strobes and arbitrates the FIFO's single access slot between writes and pops. It drains the FIFO into a valid/ready consumer port. It also keeps an exact occupancy count, which drives RTS flow control with hysteresis and a sticky overrun flag. It sits between the UART receiver and the host/bus side, and instantiates nothing.

---
 rtl/rx_fifo_drain_ctrl.sv | 145 ++++++++++++++
 tb/tb_rx_fifo_drain_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_fifo_drain_ctrl.sv
// UART receive FIFO sequencer: turns receiver strobes into FIFO writes, drains the FIFO
// into a valid/ready consumer, and tracks occupancy for RTS hysteresis and overrun.
module rx_fifo_drain_ctrl #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_WIDTH = 4,
    parameter int RTS_HI     = 12,
    parameter int RTS_LO     = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_valid,
    input  logic [DATA_BITS-1:0]  rx_data,
    input  logic                  bist_mode,
    output logic                  fifo_wr,
    output logic [DATA_BITS-1:0]  fifo_wdata,
    output logic                  fifo_pop,
    input  logic [DATA_BITS-1:0]  fifo_rdata,
    output logic                  m_valid,
    output logic [DATA_BITS-1:0]  m_data,
    input  logic                  m_ready,
    output logic [FIFO_WIDTH:0]   level,
    output logic                  rts_n,
    output logic                  overrun,
    input  logic                  ovr_clr
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    localparam logic [FIFO_WIDTH:0] LVL_ZERO = {(FIFO_WIDTH+1){1'b0}};
    localparam logic [FIFO_WIDTH:0] LVL_ONE  = {{FIFO_WIDTH{1'b0}}, 1'b1};
    localparam logic [FIFO_WIDTH:0] DEPTH_C  = {1'b1, {FIFO_WIDTH{1'b0}}};
    localparam logic [FIFO_WIDTH:0] RTS_HI_C = (FIFO_WIDTH+1)'(RTS_HI);
    localparam logic [FIFO_WIDTH:0] RTS_LO_C = (FIFO_WIDTH+1)'(RTS_LO);

    logic [1:0]           state_r;
    logic [1:0]           state_nxt_s;
    logic [FIFO_WIDTH:0]  level_r;
    logic [FIFO_WIDTH:0]  level_nxt_s;
    logic                 rts_n_r;
    logic                 rts_n_nxt_s;
    logic                 overrun_r;
    logic                 m_valid_r;
    logic [DATA_BITS-1:0] m_data_r;
    logic                 full_s;
    logic                 wr_s;
    logic                 drop_s;
    logic                 pop_s;

    // Access-slot arbitration: the receiver cannot stall, so a write always beats a pop
    always_comb begin
        full_s = (level_r == DEPTH_C);
        wr_s   = rx_valid & ~bist_mode & ~full_s;
        drop_s = rx_valid & ~bist_mode & full_s;
        pop_s  = (state_r == ST_IDLE) & (level_r != LVL_ZERO) & ~rx_valid & ~bist_mode;
    end

    // Next occupancy and RTS with hysteresis between the low and high marks
    always_comb begin
        level_nxt_s = level_r;
        if (wr_s) begin
            level_nxt_s = level_r + LVL_ONE;
        end else if (pop_s) begin
            level_nxt_s = level_r - LVL_ONE;
        end else begin
            level_nxt_s = level_r;
        end

        rts_n_nxt_s = rts_n_r;
        if (level_nxt_s >= RTS_HI_C) begin
            rts_n_nxt_s = 1'b1;
        end else if (level_nxt_s <= RTS_LO_C) begin
            rts_n_nxt_s = 1'b0;
        end else begin
            rts_n_nxt_s = rts_n_r;
        end
    end

    // Drain sequencer: pop, wait one cycle for read data, hold until accepted
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (pop_s) begin
                    state_nxt_s = ST_WAIT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT: state_nxt_s = ST_HOLD;
            ST_HOLD: begin
                if (m_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State, occupancy, flow control, overrun and consumer registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            level_r   <= LVL_ZERO;
            rts_n_r   <= 1'b0;
            overrun_r <= 1'b0;
            m_valid_r <= 1'b0;
            m_data_r  <= {DATA_BITS{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            level_r <= level_nxt_s;
            rts_n_r <= rts_n_nxt_s;
            if (drop_s) begin
                overrun_r <= 1'b1;
            end else if (ovr_clr) begin
                overrun_r <= 1'b0;
            end
            case (state_r)
                ST_WAIT: begin
                    m_valid_r <= 1'b1;
                    m_data_r  <= fifo_rdata;
                end
                ST_HOLD: begin
                    if (m_ready) begin
                        m_valid_r <= 1'b0;
                    end
                end
                default: m_valid_r <= m_valid_r;
            endcase
        end
    end

    assign fifo_wr    = wr_s;
    assign fifo_wdata = rx_data;
    assign fifo_pop   = pop_s;
    assign m_valid    = m_valid_r;
    assign m_data     = m_data_r;
    assign level      = level_r;
    assign rts_n      = rts_n_r;
    assign overrun    = overrun_r;

endmodule

// File: tb/tb_rx_fifo_drain_ctrl.sv
// Directed bench for rx_fifo_drain_ctrl with a behavioural FIFO behind the write/pop strobes.
module tb_rx_fifo_drain_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       bist_mode;
    logic       fifo_wr;
    logic [7:0] fifo_wdata;
    logic       fifo_pop;
    logic [7:0] fifo_rdata = 8'h00;
    logic       m_valid;
    logic [7:0] m_data;
    logic       m_ready;
    logic [4:0] level;
    logic       rts_n;
    logic       overrun;
    logic       ovr_clr;

    int checks  = 0;
    int errors  = 0;
    int cyc_cnt = 0;
    int pop_cyc = -100;
    int wr_cnt  = 0;
    logic mv_prev = 1'b0;
    logic [7:0] fq[$];
    logic [7:0] got[$];
    logic [4:0] prev_lvl;

    rx_fifo_drain_ctrl #(.DATA_BITS(8), .FIFO_WIDTH(4), .RTS_HI(12), .RTS_LO(4)) dut (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .bist_mode(bist_mode),
        .fifo_wr(fifo_wr), .fifo_wdata(fifo_wdata), .fifo_pop(fifo_pop), .fifo_rdata(fifo_rdata),
        .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready), .level(level),
        .rts_n(rts_n), .overrun(overrun), .ovr_clr(ovr_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // FIFO model, handshake capture and per-cycle invariants, sampled mid-cycle
    always @(negedge clk) begin
        cyc_cnt++;
        if (rst) begin
            fq.delete();
            mv_prev = 1'b0;
        end else begin
            chk("wr_pop_exclusive", {31'd0, fifo_wr & fifo_pop}, 32'd0);
            chk("level_vs_model", {27'd0, level}, fq.size());
            if (fifo_wr) begin
                fq.push_back(fifo_wdata);
                wr_cnt++;
            end
            if (fifo_pop) begin
                if (fq.size() > 0) fifo_rdata = fq.pop_front();
                pop_cyc = cyc_cnt;
            end
            if (m_valid && !mv_prev) chk("pop_to_valid_latency", cyc_cnt - pop_cyc, 32'd2);
            if (m_valid && m_ready) got.push_back(m_data);
            mv_prev = m_valid;
        end
    end

    initial begin
        logic [7:0] t1_data [3];
        t1_data[0] = 8'h11; t1_data[1] = 8'h22; t1_data[2] = 8'h33;
        rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; bist_mode = 1'b0;
        m_ready = 1'b0; ovr_clr = 1'b0;

        // Reset state
        cyc(); cyc();
        chk("rst_m_valid", m_valid, 32'd0);
        chk("rst_m_data", m_data, 32'd0);
        chk("rst_level", level, 32'd0);
        chk("rst_rts_n", rts_n, 32'd0);
        chk("rst_overrun", overrun, 32'd0);
        chk("rst_fifo_wr", fifo_wr, 32'd0);
        chk("rst_fifo_pop", fifo_pop, 32'd0);
        rst = 1'b0;
        cyc();

        // Three spaced characters drained with m_ready held high
        m_ready = 1'b1; got.delete(); wr_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            rx_valid = 1'b1; rx_data = t1_data[i];
            cyc();
            rx_valid = 1'b0;
            cyc();
        end
        repeat (8) cyc();
        chk("t1_wr_count", wr_cnt, 32'd3);
        chk("t1_got_count", got.size(), 32'd3);
        chk("t1_data0", got[0], 32'h11);
        chk("t1_data1", got[1], 32'h22);
        chk("t1_data2", got[2], 32'h33);
        chk("t1_level", level, 32'd0);

        // Fill to full with consumer stalled, then overrun and its clear priority
        m_ready = 1'b0; got.delete();
        rx_valid = 1'b1; rx_data = 8'h40;
        cyc();
        rx_valid = 1'b0;
        cyc();
        for (int i = 1; i <= 16; i++) begin
            rx_valid = 1'b1; rx_data = 8'h40 + 8'(i);
            cyc();
            if (i == 15) begin
                chk("t2_level15", level, 32'd15);
                chk("t2_hold_valid", m_valid, 32'd1);
                chk("t2_hold_data", m_data, 32'h40);
            end
        end
        chk("t2_level16", level, 32'd16);
        chk("t2_rts_full", rts_n, 32'd1);
        rx_data = 8'h99;
        #1;
        chk("t2_no_wr_full", fifo_wr, 32'd0);
        cyc();
        chk("t2_overrun_set", overrun, 32'd1);
        chk("t2_level_stays16", level, 32'd16);
        ovr_clr = 1'b1;
        cyc();
        chk("t2_set_beats_clr", overrun, 32'd1);
        rx_valid = 1'b0;
        cyc();
        chk("t2_clr", overrun, 32'd0);
        ovr_clr = 1'b0;

        // Drain from full: rts_n holds high down to 5, drops at 4
        m_ready = 1'b1;
        prev_lvl = level;
        for (int n = 0; n < 150 && got.size() < 17; n++) begin
            cyc();
            if (level != prev_lvl) chk("t3_rts_drain", rts_n, {31'd0, level >= 5'd5});
            prev_lvl = level;
        end
        chk("t3_got_count", got.size(), 32'd17);
        chk("t3_first", got[0], 32'h40);
        chk("t3_last", got[16], 32'h50);
        chk("t3_level0", level, 32'd0);

        // Fill from empty: rts_n stays low until level reaches 12
        m_ready = 1'b0; rx_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            rx_data = 8'h60 + 8'(i);
            cyc();
            if (i == 10) begin
                chk("t3_level11", level, 32'd11);
                chk("t3_rts_at11", rts_n, 32'd0);
            end
        end
        chk("t3_level12", level, 32'd12);
        chk("t3_rts_at12", rts_n, 32'd1);
        rx_valid = 1'b0; rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("t3_rst_level", level, 32'd0);
        chk("t3_rst_rts", rts_n, 32'd0);

        // Write beats a pending pop; the pop retries next cycle
        m_ready = 1'b1; got.delete();
        rx_valid = 1'b1; rx_data = 8'h71;
        cyc();
        rx_data = 8'h72;
        cyc();
        rx_data = 8'h73;
        #1;
        chk("t4_wr_wins", fifo_wr, 32'd1);
        chk("t4_pop_blocked", fifo_pop, 32'd0);
        cyc();
        chk("t4_level3", level, 32'd3);
        rx_valid = 1'b0;
        #1;
        chk("t4_pop_retry", fifo_pop, 32'd1);
        cyc();
        chk("t4_level2", level, 32'd2);
        for (int n = 0; n < 40 && got.size() < 3; n++) cyc();
        chk("t4_got_count", got.size(), 32'd3);
        chk("t4_data0", got[0], 32'h71);
        chk("t4_data2", got[2], 32'h73);

        // BIST suppresses writes and pops but lets a HOLD complete
        m_ready = 1'b0; got.delete();
        rx_valid = 1'b1; rx_data = 8'h81;
        cyc();
        rx_valid = 1'b0;
        cyc();
        for (int i = 2; i <= 6; i++) begin
            rx_valid = 1'b1; rx_data = 8'h80 + 8'(i);
            cyc();
        end
        chk("t5_level5", level, 32'd5);
        chk("t5_hold_valid", m_valid, 32'd1);
        chk("t5_hold_data", m_data, 32'h81);
        bist_mode = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rx_valid = 1'b1; rx_data = 8'h90 + 8'(i);
            #1;
            chk("t5_bist_no_wr", fifo_wr, 32'd0);
            chk("t5_bist_no_pop", fifo_pop, 32'd0);
            cyc();
        end
        chk("t5_bist_level", level, 32'd5);
        chk("t5_bist_overrun", overrun, 32'd0);
        rx_valid = 1'b0; m_ready = 1'b1;
        cyc();
        chk("t5_hold_done", m_valid, 32'd0);
        #1;
        chk("t5_bist_idle_no_pop", fifo_pop, 32'd0);
        cyc();
        chk("t5_level_kept", level, 32'd5);
        chk("t5_got", got.size(), 32'd1);
        chk("t5_got_data", got[0], 32'h81);

        // Reset in HOLD with level 7 abandons the transfer
        bist_mode = 1'b0; m_ready = 1'b0;
        #1;
        chk("t6_pop_after_bist", fifo_pop, 32'd1);
        cyc();
        for (int i = 1; i <= 3; i++) begin
            rx_valid = 1'b1; rx_data = 8'ha0 + 8'(i);
            cyc();
        end
        chk("t6_level7", level, 32'd7);
        chk("t6_in_hold", m_valid, 32'd1);
        rx_valid = 1'b0; rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("t6_m_valid", m_valid, 32'd0);
        chk("t6_m_data", m_data, 32'd0);
        chk("t6_level", level, 32'd0);
        chk("t6_rts_n", rts_n, 32'd0);
        chk("t6_overrun", overrun, 32'd0);
        rx_valid = 1'b1; rx_data = 8'hb1;
        cyc();
        rx_valid = 1'b0;
        #1;
        chk("t6_idle_pop", fifo_pop, 32'd1);
        repeat (4) cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
